usb_tx: RTL

USB_TX -- requirements
Module: usb_tx

---
 rtl/usb_pkg.sv | 27 ++
 rtl/usb_bit_timer.sv | 24 ++
 rtl/usb_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and constants for the USB packet transmitter
package usb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_EOP  = 2'd3
    } state_e;

    localparam int FS_DIV_DEFAULT = 4;
    localparam int LS_DIV_DEFAULT = 32;
    localparam int DIV_W          = 8;

    // SYNC bits in transmit order, LSB first: 0,0,0,0,0,0,0,1
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [2:0] STUFF_RUN    = 3'd6;

    // {dp, dm} for the J state; K is the bitwise inverse
    localparam logic [1:0] FS_J = 2'b10;
    localparam logic [1:0] LS_J = 2'b01;

    function automatic logic [1:0] j_level(input logic fs);
        return fs ? FS_J : LS_J;
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// rtl/usb_bit_timer.sv - loadable clock divider emitting one strobe per bit period
module usb_bit_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_div,
    output logic         o_strobe
);

    logic [W-1:0] r_cnt;

    assign o_strobe = !i_load && (r_cnt == i_div - W'(1));

    always_ff @(posedge clk) begin
        if (rst || i_load || o_strobe) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - USB LS/FS packet transmitter: SYNC, NRZI, bit stuffing, EOP
module usb_tx
    import usb_pkg::*;
#(
    parameter int FS_DIV = FS_DIV_DEFAULT,
    parameter int LS_DIV = LS_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_fs,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp,
    output logic       dm,
    output logic       oe,
    output logic       busy,
    output logic       err
);

    state_e     r_state;
    logic       r_fs;
    logic       r_oe;
    logic       r_err;
    logic       r_dp;
    logic       r_dm;
    logic       r_hold_full;
    logic [7:0] r_hold_data;
    logic       r_hold_last;
    logic [7:0] r_shift;
    logic       r_cur_last;
    logic [2:0] r_bitcnt;
    logic [2:0] r_run;
    logic [1:0] r_eopcnt;

    logic             w_accept;
    logic             w_strobe;
    logic             w_timer_load;
    logic [DIV_W-1:0] w_div;
    logic             w_load;
    logic             w_eop_start;
    logic             w_underrun;
    logic             w_bit;
    logic [2:0]       w_sync_idx;

    assign tx_ready     = !r_hold_full && (r_state != ST_EOP);
    assign w_accept     = tx_valid && tx_ready;
    assign w_timer_load = (r_state == ST_IDLE);
    assign w_div        = r_fs ? DIV_W'(FS_DIV) : DIV_W'(LS_DIV);
    assign w_sync_idx   = r_bitcnt + 3'd1;

    assign dp   = r_dp;
    assign dm   = r_dm;
    assign oe   = r_oe;
    assign busy = r_oe;
    assign err  = r_err;

    usb_bit_timer #(.W(DIV_W)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_timer_load),
        .i_div    (w_div),
        .o_strobe (w_strobe)
    );

    // Decide what the next bit boundary does when no stuff bit is pending
    always_comb begin
        w_load      = 1'b0;
        w_eop_start = 1'b0;
        w_underrun  = 1'b0;
        w_bit       = 1'b0;
        if (r_state == ST_SYNC) begin
            if (r_bitcnt != 3'd7) begin
                w_bit = SYNC_PATTERN[w_sync_idx];
            end else begin
                w_load = 1'b1;
                w_bit  = r_hold_data[0];
            end
        end else if (r_bitcnt != 3'd7) begin
            w_bit = r_shift[1];
        end else if (r_cur_last) begin
            w_eop_start = 1'b1;
        end else if (r_hold_full) begin
            w_load = 1'b1;
            w_bit  = r_hold_data[0];
        end else begin
            w_eop_start = 1'b1;
            w_underrun  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_fs             <= is_fs;
            r_oe             <= 1'b0;
            r_err            <= 1'b0;
            {r_dp, r_dm}     <= j_level(is_fs);
            r_hold_full      <= 1'b0;
            r_hold_data      <= 8'h00;
            r_hold_last      <= 1'b0;
            r_shift          <= 8'h00;
            r_cur_last       <= 1'b0;
            r_bitcnt         <= 3'd0;
            r_run            <= 3'd0;
            r_eopcnt         <= 2'd0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_data <= tx_data;
                r_hold_last <= tx_last;
            end
            case (r_state)
                ST_IDLE: begin
                    r_fs         <= is_fs;
                    r_oe         <= 1'b0;
                    {r_dp, r_dm} <= j_level(is_fs);
                    if (w_accept || r_hold_full) begin
                        // First SYNC bit is a 0, so the line leaves idle J straight to K
                        r_state      <= ST_SYNC;
                        r_oe         <= 1'b1;
                        {r_dp, r_dm} <= ~j_level(is_fs);
                        r_bitcnt     <= 3'd0;
                        r_run        <= 3'd0;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (w_strobe) begin
                        if (r_run == STUFF_RUN) begin
                            r_dp  <= ~r_dp;
                            r_dm  <= ~r_dm;
                            r_run <= 3'd0;
                        end else if (w_eop_start) begin
                            r_state  <= ST_EOP;
                            r_eopcnt <= 2'd0;
                            r_dp     <= 1'b0;
                            r_dm     <= 1'b0;
                            r_err    <= w_underrun;
                        end else begin
                            if (w_load) begin
                                r_state     <= ST_DATA;
                                r_shift     <= r_hold_data;
                                r_cur_last  <= r_hold_last;
                                r_hold_full <= 1'b0;
                                r_bitcnt    <= 3'd0;
                            end else begin
                                r_shift  <= r_shift >> 1;
                                r_bitcnt <= r_bitcnt + 3'd1;
                            end
                            if (w_bit) begin
                                r_run <= r_run + 3'd1;
                            end else begin
                                r_dp  <= ~r_dp;
                                r_dm  <= ~r_dm;
                                r_run <= 3'd0;
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (w_strobe) begin
                        r_eopcnt <= r_eopcnt + 2'd1;
                        if (r_eopcnt == 2'd1) begin
                            {r_dp, r_dm} <= j_level(r_fs);
                        end
                        if (r_eopcnt == 2'd2) begin
                            r_state      <= ST_IDLE;
                            r_oe         <= 1'b0;
                            {r_dp, r_dm} <= j_level(is_fs);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
